// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a five-stage pipeline. Holds the program
// counter, reads an asynchronous instruction memory, assembles one-word and
// two-word (opcode + immediate) instructions and drives the fetch/decode
// pipeline register.
//
// Ports:
//   clk            in   single clock, all state updates on the rising edge
//   rst            in   synchronous active-low reset
//   stall          in   hazard-unit stall: hold PC, FSM, hold register, F/D
//   FD_reset       in   branch flush: redirect PC, squash in-flight fetch
//   branch_target  in   redirect address, used only when FD_reset=1
//   imem_addr      out  instruction-memory address (always the PC register)
//   imem_data      in   instruction-memory read data for imem_addr
//   fd_instr       out  opcode word to decode
//   fd_imm         out  immediate word (0 for one-word instructions)
//   fd_pc          out  address of the opcode word
//   fd_valid       out  F/D register holds a real instruction (0 = bubble)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          INSTR_WIDTH  = 16,
    parameter int unsigned          IMM_BIT      = 15,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = {PC_WIDTH{1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   FD_reset,
    input  logic [PC_WIDTH-1:0]    branch_target,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    output logic [INSTR_WIDTH-1:0] fd_instr,
    output logic [INSTR_WIDTH-1:0] fd_imm,
    output logic [PC_WIDTH-1:0]    fd_pc,
    output logic                   fd_valid
);

    typedef enum logic [0:0] {
        ST_OP  = 1'b0,   // next word is an opcode
        ST_IMM = 1'b1    // next word is the immediate of a held opcode
    } state_t;

    state_t                 state_q,    state_d;
    logic [PC_WIDTH-1:0]    pc_q,       pc_d;
    logic [INSTR_WIDTH-1:0] hold_q,     hold_d;
    logic [INSTR_WIDTH-1:0] fd_instr_q, fd_instr_d;
    logic [INSTR_WIDTH-1:0] fd_imm_q,   fd_imm_d;
    logic [PC_WIDTH-1:0]    fd_pc_q,    fd_pc_d;
    logic                   fd_valid_q, fd_valid_d;

    logic [PC_WIDTH-1:0]    pc_inc_s;
    logic [PC_WIDTH-1:0]    pc_dec_s;

    // Modulo-2^PC_WIDTH neighbours of the PC; a two-word instruction may
    // straddle the wrap point, so PC-1 of address 0 is all-ones.
    assign pc_inc_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign pc_dec_s = pc_q - {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Memory address comes straight from the register so it only moves on
    // a rising edge.
    assign imem_addr = pc_q;
    assign fd_instr  = fd_instr_q;
    assign fd_imm    = fd_imm_q;
    assign fd_pc     = fd_pc_q;
    assign fd_valid  = fd_valid_q;

    // Next-state logic: flush beats stall beats normal fetch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        fd_instr_d = fd_instr_q;
        fd_imm_d   = fd_imm_q;
        fd_pc_d    = fd_pc_q;
        fd_valid_d = fd_valid_q;

        if (FD_reset) begin
            // Redirect; any half-assembled instruction is dropped. The
            // payload fields are left alone since fd_valid marks a bubble.
            pc_d       = branch_target;
            state_d    = ST_OP;
            hold_d     = {INSTR_WIDTH{1'b0}};
            fd_valid_d = 1'b0;
        end else if (stall) begin
            // Everything holds, including fd_valid.
            state_d = state_q;
        end else begin
            pc_d = pc_inc_s;
            case (state_q)
                ST_OP: begin
                    if (imem_data[IMM_BIT]) begin
                        // Opcode of a two-word instruction: park it and
                        // emit a bubble while the immediate is fetched.
                        hold_d     = imem_data;
                        fd_valid_d = 1'b0;
                        state_d    = ST_IMM;
                    end else begin
                        fd_instr_d = imem_data;
                        fd_imm_d   = {INSTR_WIDTH{1'b0}};
                        fd_pc_d    = pc_q;
                        fd_valid_d = 1'b1;
                        state_d    = ST_OP;
                    end
                end
                ST_IMM: begin
                    // The word here is data regardless of its IMM_BIT.
                    fd_instr_d = hold_q;
                    fd_imm_d   = imem_data;
                    fd_pc_d    = pc_dec_s;
                    fd_valid_d = 1'b1;
                    state_d    = ST_OP;
                end
                default: begin
                    state_d    = ST_OP;
                    fd_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and F/D register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_OP;
            pc_q       <= RESET_VECTOR;
            hold_q     <= {INSTR_WIDTH{1'b0}};
            fd_instr_q <= {INSTR_WIDTH{1'b0}};
            fd_imm_q   <= {INSTR_WIDTH{1'b0}};
            fd_pc_q    <= {PC_WIDTH{1'b0}};
            fd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            fd_instr_q <= fd_instr_d;
            fd_imm_q   <= fd_imm_d;
            fd_pc_q    <= fd_pc_d;
            fd_valid_q <= fd_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        FD_reset;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] fd_instr;
    logic [15:0] fd_imm;
    logic [31:0] fd_pc;
    logic        fd_valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .FD_reset      (FD_reset),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .fd_instr      (fd_instr),
        .fd_imm        (fd_imm),
        .fd_pc         (fd_pc),
        .fd_valid      (fd_valid)
    );

    // 256-word memory image, aliased across the whole address space.
    logic [15:0] mem [0:255];
    always_comb imem_data = mem[imem_addr[7:0]];

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic [31:0] pc;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: instruction-stream view of the program.
    logic [31:0] m_pc;
    logic [31:0] m_start;
    int          m_used;
    int          m_len;
    rec_t        m_last;
    logic        m_valid;
    logic        adv_s   = 1'b0;
    logic        mon_adv = 1'b0;

    function automatic logic [15:0] rd(input logic [31:0] a);
        return mem[a[7:0]];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // One clock edge: drive inputs, advance the model, then check state.
    task automatic step(input logic r, input logic st, input logic fl, input logic [31:0] tgt);
        rec_t rec;
        rst = r; stall = st; FD_reset = fl; branch_target = tgt;
        adv_s = 1'b0;
        if (!r) begin
            m_pc = 32'h0; m_used = 0; m_last = '0; m_valid = 1'b0;
        end else if (fl) begin
            m_pc = tgt; m_used = 0; m_valid = 1'b0;
        end else if (!st) begin
            if (m_used == 0) begin
                m_start = m_pc;
                m_len   = rd(m_pc)[15] ? 2 : 1;
            end
            m_used++;
            m_pc = m_pc + 32'd1;
            if (m_used == m_len) begin
                rec.instr = rd(m_start);
                rec.imm   = (m_len == 2) ? rd(m_start + 32'd1) : 16'h0;
                rec.pc    = m_start;
                exp_q.push_back(rec);
                m_last  = rec;
                m_valid = 1'b1;
                m_used  = 0;
                adv_s   = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("fd_valid",  64'(fd_valid),  64'(m_valid));
        chk("fd_instr",  64'(fd_instr),  64'(m_last.instr));
        chk("fd_imm",    64'(fd_imm),    64'(m_last.imm));
        chk("fd_pc",     64'(fd_pc),     64'(m_last.pc));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    // Latch whether the edge just taken should have issued an instruction.
    always @(posedge clk) mon_adv <= adv_s;

    // Scoreboard monitor: each newly issued instruction is popped and compared.
    always @(negedge clk) begin
        rec_t e;
        if (mon_adv) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL issue_unexpected actual=%0h/%0h/%0h required=none", fd_instr, fd_imm, fd_pc);
            end else begin
                e = exp_q.pop_front();
                chk("issue_valid", 64'(fd_valid), 64'd1);
                chk("issue_instr", 64'(fd_instr), 64'(e.instr));
                chk("issue_imm",   64'(fd_imm),   64'(e.imm));
                chk("issue_pc",    64'(fd_pc),    64'(e.pc));
            end
        end
    end

    initial begin
        rst = 1'b0; stall = 1'b0; FD_reset = 1'b0; branch_target = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i) & 16'h7FFF;
        mem[0] = 16'h0011; mem[1] = 16'h0022; mem[2] = 16'h0033;
        mem[3] = 16'h0044; mem[4] = 16'h8005; mem[5] = 16'hBEEF;
        mem[6] = 16'h0066; mem[8'h20] = 16'h1234; mem[8'hFF] = 16'h00FF;

        // Reset with arbitrary other inputs.
        step(1'b0, 1'($urandom), 1'($urandom), $urandom);
        step(1'b0, 1'($urandom), 1'($urandom), $urandom);

        // Sequential one-word fetch, then the two-word instruction at 4.
        run(4);
        run(2);
        run(1);

        // Flush while in IMM at PC=5.
        step(1'b1, 1'b0, 1'b1, 32'h4);
        run(1);
        step(1'b1, 1'b0, 1'b1, 32'h20);
        run(1);

        // Stall freeze, then stall+flush together: flush wins.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);

        // Wrap: one-word at all-ones, then address 0.
        run(2);

        // Reset in the middle of a two-word instruction.
        step(1'b1, 1'b0, 1'b1, 32'h4);
        run(1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        run(3);

        // Two-word instruction straddling the wrap point.
        mem[8'hFF] = 16'h80AA;
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        run(3);

        // Randomized program and control traffic.
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            logic        r, st, fl;
            logic [31:0] t;
            r  = ($urandom % 64) != 0;
            fl = ($urandom % 16) == 0;
            st = ($urandom % 5) == 0;
            t  = (($urandom % 4) == 0) ? (32'hFFFF_FFFF - 32'($urandom % 3)) : 32'($urandom % 256);
            step(r, st, fl, t);
        end

        @(negedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
